// File: rtl/axi_adc_jesd204_capture_pkg.sv
// Shared state encoding and trigger helper
// for the ADC capture sequencer.
package axi_adc_jesd204_capture_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] DELAY   = 2'd2;
  localparam logic [1:0] CAPTURE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_ARMED   = ARMED,
    ST_DELAY   = DELAY,
    ST_CAPTURE = CAPTURE
  } state_t;

  function automatic logic trig_edge(
    input logic cur,
    input logic prev,
    input logic rising
  );
    return rising ? (cur & ~prev) : (~cur & prev);
  endfunction

endpackage

// File: rtl/axi_adc_jesd204_trig_detect.sv
// Registers trig_in and flags the selected
// edge in the cycle the new level appears.
module axi_adc_jesd204_trig_detect
  import axi_adc_jesd204_capture_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic trig_in,
  input  logic rising,
  output logic trig_evt
);

  logic trig_d_q;
  logic trig_d_d;

  // next value of the delayed trigger
  always_comb begin
    trig_d_d = trig_in;
  end

  // delayed trigger flop
  always_ff @(posedge clk) begin
    if (!rstn) trig_d_q <= 1'b0;
    else       trig_d_q <= trig_d_d;
  end

  assign trig_evt = trig_edge(trig_in, trig_d_q, rising);

endmodule

// File: rtl/axi_adc_jesd204_capture_ctrl.sv
// Capture sequencer: arm, optional trigger,
// post-trigger skip, then N beats to the DMA.
module axi_adc_jesd204_capture_ctrl
  import axi_adc_jesd204_capture_pkg::*;
#(
  parameter int NUM_CHANNELS = 1,
  parameter int DATA_WIDTH   = 32,
  parameter int LENGTH_WIDTH = 24,
  parameter int DELAY_WIDTH  = 16
) (
  input  logic                    adc_clk,
  input  logic                    adc_rstn,
  input  logic                    ctrl_arm,
  input  logic                    ctrl_abort,
  input  logic                    ctrl_continuous,
  input  logic                    ctrl_trig_en,
  input  logic                    ctrl_trig_rising,
  input  logic [DELAY_WIDTH-1:0]  ctrl_delay,
  input  logic [LENGTH_WIDTH-1:0] ctrl_length,
  input  logic                    trig_in,
  input  logic [NUM_CHANNELS-1:0] adc_valid_in,
  input  logic [DATA_WIDTH-1:0]   adc_data_in,
  input  logic                    adc_dovf,
  output logic [NUM_CHANNELS-1:0] dma_valid,
  output logic [DATA_WIDTH-1:0]   dma_data,
  output logic                    dma_sync,
  output logic                    status_busy,
  output logic                    status_done,
  output logic                    status_ovf,
  output logic [LENGTH_WIDTH-1:0] status_count
);

  state_t state_q, state_d;

  logic [DELAY_WIDTH-1:0]  delay_q, delay_d;
  logic [DELAY_WIDTH-1:0]  dly_cnt_q, dly_cnt_d;
  logic [LENGTH_WIDTH-1:0] length_q, length_d;
  logic [LENGTH_WIDTH-1:0] cnt_q, cnt_d;
  logic                    trig_en_q, trig_en_d;
  logic                    rising_q, rising_d;
  logic                    first_q, first_d;
  logic [NUM_CHANNELS-1:0] valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    sync_q, sync_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, busy_d;

  logic trig_evt;

  axi_adc_jesd204_trig_detect u_trig (
    .clk      (adc_clk),
    .rstn     (adc_rstn),
    .trig_in  (trig_in),
    .rising   (rising_q),
    .trig_evt (trig_evt)
  );

  logic beat;
  logic in_dly;
  logic take;
  logic fin;

  // next-state and output decode
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    dly_cnt_d = dly_cnt_q;
    length_d  = length_q;
    cnt_d     = cnt_q;
    trig_en_d = trig_en_q;
    rising_d  = rising_q;
    first_d   = first_q;
    ovf_d     = ovf_q;
    valid_d   = '0;
    data_d    = adc_data_in;
    sync_d    = 1'b0;
    done_d    = 1'b0;
    beat      = adc_valid_in[0];
    in_dly    = 1'b0;
    take      = 1'b0;
    fin       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_arm && !ctrl_abort) begin
          delay_d   = ctrl_delay;
          length_d  = ctrl_length;
          dly_cnt_d = ctrl_delay;
          trig_en_d = ctrl_trig_en;
          rising_d  = ctrl_trig_rising;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          first_d   = 1'b1;
          if (ctrl_length == '0 && !ctrl_trig_en) begin
            done_d = 1'b1;
            fin    = 1'b1;
          end else begin
            state_d = ctrl_trig_en ? ST_ARMED
                                   : ST_DELAY;
          end
        end
      end
      ST_ARMED: begin
        if (trig_evt) begin
          if (length_q == '0) begin
            done_d = 1'b1;
            fin    = 1'b1;
          end else begin
            state_d = ST_DELAY;
            in_dly  = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        if (length_q == '0) begin
          done_d = 1'b1;
          fin    = 1'b1;
        end else begin
          in_dly = 1'b1;
        end
      end
      ST_CAPTURE: begin
        take = beat;
      end
    endcase

    if (in_dly && beat) begin
      if (dly_cnt_q == '0) begin
        take = 1'b1;
      end else begin
        dly_cnt_d = dly_cnt_q - 1'b1;
        if (dly_cnt_q == DELAY_WIDTH'(1))
          state_d = ST_CAPTURE;
      end
    end

    if (take) begin
      cnt_d   = first_q ? LENGTH_WIDTH'(1)
                        : cnt_q + 1'b1;
      first_d = 1'b0;
      valid_d = adc_valid_in;
      sync_d  = first_q;
      state_d = ST_CAPTURE;
      if (cnt_d == length_q) begin
        done_d = 1'b1;
        fin    = 1'b1;
      end
    end

    if (fin) begin
      first_d = 1'b1;
      if (ctrl_continuous) begin
        state_d   = trig_en_d ? ST_ARMED
                              : ST_DELAY;
        dly_cnt_d = delay_d;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (state_q == ST_CAPTURE && adc_dovf)
      ovf_d = 1'b1;

    if (ctrl_abort) begin
      state_d   = ST_IDLE;
      valid_d   = '0;
      sync_d    = 1'b0;
      done_d    = 1'b0;
      cnt_d     = cnt_q;
      first_d   = first_q;
      dly_cnt_d = dly_cnt_q;
      delay_d   = delay_q;
      length_d  = length_q;
      trig_en_d = trig_en_q;
      rising_d  = rising_q;
      ovf_d     = ovf_q | (state_q == ST_CAPTURE
                           && adc_dovf);
    end

    busy_d = (state_d != ST_IDLE) || done_d;
  end

  // all sequencer state and registered outputs
  always_ff @(posedge adc_clk) begin
    if (!adc_rstn) begin
      state_q   <= ST_IDLE;
      delay_q   <= '0;
      dly_cnt_q <= '0;
      length_q  <= '0;
      cnt_q     <= '0;
      trig_en_q <= 1'b0;
      rising_q  <= 1'b0;
      first_q   <= 1'b0;
      valid_q   <= '0;
      data_q    <= '0;
      sync_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      dly_cnt_q <= dly_cnt_d;
      length_q  <= length_d;
      cnt_q     <= cnt_d;
      trig_en_q <= trig_en_d;
      rising_q  <= rising_d;
      first_q   <= first_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      sync_q    <= sync_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign dma_valid    = valid_q;
  assign dma_data     = data_q;
  assign dma_sync     = sync_q;
  assign status_busy  = busy_q;
  assign status_done  = done_q;
  assign status_ovf   = ovf_q;
  assign status_count = cnt_q;

endmodule

// File: doc/axi_adc_jesd204_capture_ctrl.md
Name: axi_adc_jesd204_capture_ctrl

Overview:
- Capture sequencer between the JESD204 ADC core's DMA-side outputs (enable/valid/data/dovf) and the DMA.
- Arms on a software request and optionally waits for an external trigger edge.
- After the trigger it skips a programmable number of beats, then passes exactly N beats to the DMA.
- Supports single-shot or continuous re-arming, reports busy/done/overflow status, and runs entirely in the ADC clock domain.

Parameters:
- NUM_CHANNELS, 1, number of converter channels (valid/enable width).
- DATA_WIDTH, 32, data bus width (NUM_LANES*32).
- LENGTH_WIDTH, 24, capture length counter width, in beats.
- DELAY_WIDTH, 16, post-trigger delay counter width, in beats.

Ports:
- adc_clk  in  1  ADC/JESD link clock (line-rate/40).
- adc_rstn  in  1  synchronous active-low reset.
- ctrl_arm  in  1  one-cycle arm request.
- ctrl_abort  in  1  one-cycle abort request.
- ctrl_continuous  in  1  re-arm automatically after each capture.
- ctrl_trig_en  in  1  wait for trigger before delay/capture.
- ctrl_trig_rising  in  1  1: rising edge, 0: falling edge of trig_in.
- ctrl_delay  in  DELAY_WIDTH  beats skipped after trigger; latched at arm.
- ctrl_length  in  LENGTH_WIDTH  beats captured; latched at arm.
- trig_in  in  1  external trigger, already synchronous to adc_clk.
- adc_valid_in  in  NUM_CHANNELS  per-channel valid from core.
- adc_data_in  in  DATA_WIDTH  sample data from core.
- adc_dovf  in  1  DMA overflow.
- dma_valid  out  NUM_CHANNELS  gated valid.
- dma_data  out  DATA_WIDTH  registered data.
- dma_sync  out  1  marks first beat of each capture.
- status_busy  out  1  state != IDLE.
- status_done  out  1  one-cycle pulse per completed capture.
- status_ovf  out  1  sticky overflow seen during CAPTURE.
- status_count  out  LENGTH_WIDTH  beats captured in current/last capture.

Behaviour:
- Reset (adc_rstn=0 at a clock edge): state=IDLE; all outputs 0; latched delay/length 0; trig_d=0. Reset mid-capture aborts silently, with no done pulse.
- Beat: a cycle with adc_valid_in[0]=1. All enabled channels are valid together.
- Trigger event: (trig_in & ~trig_d) if ctrl_trig_rising, else (~trig_in & trig_d). trig_d is trig_in registered.
- Output latency: dma_data = adc_data_in delayed 1 cycle, always. dma_valid = adc_valid_in delayed 1 cycle, only for beats counted as captured; 0 otherwise.
- States: IDLE, ARMED, DELAY, CAPTURE.
- IDLE: on ctrl_arm, latch delay/length, clear status_ovf and status_count. Next state is ARMED if ctrl_trig_en, else DELAY.
- ARMED: on a trigger event, go to DELAY. The beat in the trigger cycle is the first beat counted in DELAY/CAPTURE.
- DELAY: skip delay beats. If delay=0, the first qualifying beat is captured in the same cycle (no dead beat). Delay counter decrements per beat; on the last skipped beat, go to CAPTURE.
- CAPTURE: each beat increments status_count. dma_sync=1 on the first beat's output cycle. On the beat where count reaches length:
  - pulse status_done, aligned with that last beat's dma_valid;
  - next state is IDLE if not continuous, else ARMED/DELAY per ctrl_trig_en, with status_count reset on the next first beat.
- Length 0: no beats captured. status_done pulses one cycle after the arm/trigger-resolve, then the single-shot/continuous rule above applies.
- ctrl_abort: any state -> IDLE next cycle, no done. If a beat coincides with the abort cycle, it is not output. Abort wins over arm in the same cycle.
- ctrl_arm while not IDLE: ignored.
- adc_dovf=1 in CAPTURE: sets status_ovf, which stays set until the next accepted arm. Capture continues.
- ctrl_* changes after arm do not affect the current capture. ctrl_continuous is sampled at completion.
- Counters never wrap: they saturate on the terminal compare.

Decomposition:
- Package axi_adc_jesd204_capture_pkg: state encoding localparams (IDLE=2'd0, ARMED=2'd1, DELAY=2'd2, CAPTURE=2'd3).
- Sub-module axi_adc_jesd204_trig_detect: registers trig_in and outputs a one-cycle edge pulse per ctrl_trig_rising.

Test Plan:
- Untriggered single shot, delay=0, length=8, continuous valid -> first valid beat after arm captured, 8 dma_valid beats, dma_sync on beat 1, status_done on beat 8, status_count=8, busy drops next cycle.
- Triggered rising, delay=3, length=4, valid every 2nd cycle -> beats 0-2 after trigger (counting the trigger-cycle beat) dropped, beats 3-6 passed, falling edges ignored.
- Continuous, trig_en=0, length=5, 20 beats -> 4 done pulses, dma_sync every 5th beat, no gap beats.
- Abort at capture beat 3 of 10 with arm in the same cycle -> IDLE, no done, no further dma_valid, status_count=2 or 3 per output alignment (bench checks it equals the beats emitted).
- adc_dovf pulse mid-capture -> status_ovf=1, capture completes with count=length; next arm clears ovf.
- Reset asserted mid-DELAY -> all outputs 0 next cycle; subsequent arm works normally.
